// File: rtl/approx_acc_8bit_if.sv
// Stream bundle for approx_acc_8bit: product input and result output channels,
// both using valid/ready handshakes.
interface approx_acc_8bit_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/approx_acc_8bit.sv
// Saturating streaming accumulator: sums up to LEN unsigned product terms per
// vector and presents the total, term count and saturation flag on a registered output.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_EMPTY | no terms held, acc = 0 and cnt = 0
//   ST_ACCUM | at least one term of the current vector held
module approx_acc_8bit #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int LEN    = 16,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    approx_acc_8bit_if.slave  bus
);
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {ST_EMPTY, ST_ACCUM} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_sat_q, out_sat_d;

    logic               in_ready;
    logic               in_fire;
    logic               out_fire;
    logic               term_final;
    logic [SUM_W-1:0]   sum_w;
    logic               ovf;
    logic [ACC_W-1:0]   acc_n;
    logic [CNT_W-1:0]   cnt_n;

    // Ready depends only on the result slot, so a final term can always be taken
    // in the same cycle the pending result drains.
    assign in_ready   = !out_valid_q | bus.out_ready;
    assign in_fire    = bus.in_valid & in_ready;
    assign out_fire   = out_valid_q & bus.out_ready;
    assign term_final = bus.in_last | (cnt_q == CNT_W'(LEN - 1));

    assign sum_w = {1'b0, acc_q} + SUM_W'(bus.in_prod);
    assign ovf   = sum_w[ACC_W];
    assign acc_n = ovf ? '1 : sum_w[ACC_W-1:0];
    assign cnt_n = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            ST_EMPTY: if (in_fire && !term_final) state_d = ST_ACCUM;
            ST_ACCUM: if (in_fire && term_final)  state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (out_fire) out_valid_d = 1'b0;

        if (in_fire) begin
            if (term_final) begin
                // Publish overrides the drain so back-to-back vectors never bubble.
                out_valid_d = 1'b1;
                out_sum_d   = acc_n;
                out_count_d = cnt_n;
                out_sat_d   = sat_q | ovf;
                acc_d       = '0;
                cnt_d       = '0;
                sat_d       = 1'b0;
            end else begin
                acc_d = acc_n;
                cnt_d = cnt_n;
                sat_d = sat_q | ovf;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_approx_acc_8bit.sv
// Scoreboard bench for approx_acc_8bit: a 12-bit and a 10-bit accumulator instance
// share one stimulus driver, selected by sel; a forked monitor checks every result.
module tb_approx_acc_8bit;
    typedef struct {
        logic [11:0] s;
        logic [4:0]  c;
        logic        sat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       in_valid;
    logic [7:0] in_prod;
    logic       in_last;
    logic       out_ready;
    logic       rand_rdy;
    logic       rnd_rdy;
    logic       fixed_rdy;

    logic        cur_ir, cur_ov, cur_sat;
    logic [11:0] cur_sum;
    logic [4:0]  cur_cnt;

    int   tot = 0;
    int   bad = 0;
    int   last_wait = 0;
    exp_t sb[$];
    logic [7:0] vec [16];

    always #5 clk = ~clk;

    approx_acc_8bit_if #(.PROD_W(8), .ACC_W(12), .CNT_W(5)) if12 ();
    approx_acc_8bit_if #(.PROD_W(8), .ACC_W(10), .CNT_W(5)) if10 ();

    approx_acc_8bit #(.PROD_W(8), .ACC_W(12), .LEN(16)) dut12 (
        .clk(clk), .rst_n(rst_n), .bus(if12.slave));
    approx_acc_8bit #(.PROD_W(8), .ACC_W(10), .LEN(16)) dut10 (
        .clk(clk), .rst_n(rst_n), .bus(if10.slave));

    assign out_ready = rand_rdy ? rnd_rdy : fixed_rdy;

    assign if12.in_valid  = in_valid & ~sel;
    assign if12.in_prod   = in_prod;
    assign if12.in_last   = in_last;
    assign if12.out_ready = out_ready | sel;
    assign if10.in_valid  = in_valid & sel;
    assign if10.in_prod   = in_prod;
    assign if10.in_last   = in_last;
    assign if10.out_ready = out_ready | ~sel;

    assign cur_ir  = sel ? if10.in_ready  : if12.in_ready;
    assign cur_ov  = sel ? if10.out_valid : if12.out_valid;
    assign cur_sat = sel ? if10.out_sat   : if12.out_sat;
    assign cur_sum = sel ? {2'b00, if10.out_sum} : if12.out_sum;
    assign cur_cnt = sel ? if10.out_count : if12.out_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_term(input logic [7:0] p, input logic last, input bit fin,
                              input logic [11:0] es, input logic [4:0] ec, input logic esat);
        int waitc = 0;
        exp_t e;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (cur_ir) break;
            waitc++;
            if (waitc > 200) begin
                tot++;
                bad++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, want accept", waitc);
                break;
            end
            tick();
        end
        last_wait = waitc;
        if (fin) begin
            e.s = es; e.c = ec; e.sat = esat;
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference: terms are non-negative, so a saturating running sum equals min(total, max)
    // and saturation happened exactly when the plain total exceeds max.
    task automatic send_vec(input int n, input logic last_end, input int idle_max);
        int total = 0;
        int mx;
        logic [11:0] es;
        mx = sel ? 1023 : 4095;
        for (int i = 0; i < n; i++) total += int'(vec[i]);
        es = (total > mx) ? 12'(mx) : 12'(total);
        for (int i = 0; i < n; i++) begin
            if (idle_max > 0 && $urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, idle_max)) tick();
            drive_term(vec[i], (i == n - 1) ? last_end : 1'b0, i == n - 1,
                       es, 5'(n), total > mx);
        end
    endtask

    task automatic drain();
        int c = 0;
        while ((sb.size() != 0 || cur_ov) && c < 500) begin
            tick();
            c++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic run_ready();
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic run_monitor();
        bit          hold = 0;
        logic [11:0] hs;
        logic [4:0]  hc;
        logic        hsat;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0;
                continue;
            end
            if (hold) begin
                chk("hold_valid", cur_ov, 1);
                chk("hold_stable", {hs, hc, hsat}, {cur_sum, cur_cnt, cur_sat});
            end
            if (cur_ov && out_ready) begin
                if (sb.size() == 0) begin
                    tot++;
                    bad++;
                    $display("FAIL spurious_result: got sum %0h count %0d, want none", cur_sum, cur_cnt);
                end else begin
                    e = sb.pop_front();
                    chk("sum", cur_sum, e.s);
                    chk("count", cur_cnt, e.c);
                    chk("sat", cur_sat, e.sat);
                end
            end
            hold = cur_ov && !out_ready;
            hs = cur_sum; hc = cur_cnt; hsat = cur_sat;
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
        rand_rdy = 1'b0; rnd_rdy = 1'b1; fixed_rdy = 1'b1;
        fork
            run_monitor();
            run_ready();
        join_none

        #3;
        chk("rst_out_valid", cur_ov, 0);
        chk("rst_out_sum", cur_sum, 0);
        chk("rst_out_count", cur_cnt, 0);
        chk("rst_out_sat", cur_sat, 0);
        chk("rst_in_ready", cur_ir, 1);
        chk("rst_out_valid10", if10.out_valid, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Auto-close at LEN with in_last never set.
        for (int i = 0; i < 16; i++) vec[i] = 8'hFF;
        send_vec(16, 1'b0, 0);
        drain();

        // Back-to-back vectors, no bubble.
        vec[0] = 8'd3; vec[1] = 8'd5; vec[2] = 8'd7;
        send_vec(3, 1'b1, 0);
        vec[0] = 8'h10;
        send_vec(1, 1'b1, 0);
        chk("no_bubble_wait", last_wait, 0);
        drain();

        // in_last on the LEN-th term closes once.
        for (int i = 0; i < 16; i++) vec[i] = 8'd1;
        send_vec(16, 1'b1, 0);
        vec[0] = 8'd0; vec[1] = 8'd0;
        send_vec(2, 1'b1, 0);
        drain();

        // Narrow accumulator saturation, then a clean vector.
        sel = 1'b1;
        for (int i = 0; i < 5; i++) vec[i] = 8'hFF;
        send_vec(5, 1'b1, 0);
        vec[0] = 8'd2;
        send_vec(1, 1'b1, 0);
        drain();
        sel = 1'b0;
        tick();

        // Backpressure: pending result blocks input, then drain and publish on one edge.
        fixed_rdy = 1'b0;
        vec[0] = 8'd4;
        send_vec(1, 1'b1, 0);
        in_valid = 1'b1; in_prod = 8'd9; in_last = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("bp_in_ready", cur_ir, 0);
            chk("bp_out_sum", cur_sum, 12'd4);
            tick();
        end
        fixed_rdy = 1'b1;
        drive_term(8'd9, 1'b1, 1'b1, 12'd9, 5'd1, 1'b0);
        chk("bp_publish_valid", cur_ov, 1);
        chk("bp_publish_sum", cur_sum, 12'd9);
        drain();

        // Asynchronous reset mid-vector.
        for (int i = 0; i < 4; i++) drive_term(8'd20, 1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", cur_ov, 0);
        chk("arst_out_sum", cur_sum, 0);
        chk("arst_out_count", cur_cnt, 0);
        chk("arst_out_sat", cur_sat, 0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        vec[0] = 8'd1; vec[1] = 8'd1;
        send_vec(2, 1'b1, 0);
        drain();

        // Random throttled vectors on both widths.
        rand_rdy = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            int n;
            if (v == 500) begin
                drain();
                sel = 1'b1;
                tick();
            end
            n = ($urandom_range(0, 3) == 0) ? 16 : int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 7))
                    0:       vec[i] = 8'h00;
                    1:       vec[i] = 8'hFF;
                    default: vec[i] = 8'($urandom_range(0, 255));
                endcase
            end
            send_vec(n, (n < 16) ? 1'b1 : 1'($urandom_range(0, 1)), 2);
        end
        drain();
        rand_rdy = 1'b0;

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
